// File: rtl/carregador_matriz_if.sv
// Element input handshake and packed-matrix output bus between the loader, its producer and ula_determinante.
interface carregador_matriz_if #(
  parameter int LARGURA_ELEM = 8,
  parameter int MAX_ELEM     = 25
);
  logic signed [LARGURA_ELEM-1:0]          in_data;
  logic                                    in_valid;
  logic                                    in_ready;
  logic signed [LARGURA_ELEM*MAX_ELEM-1:0] matriz;
  logic [1:0]                              tamanho_matriz;
  logic                                    mat_valid;
  logic                                    mat_ack;

  // slave is the loader itself; master is the producer/consumer environment around it
  modport slave (
    input  in_data, in_valid, mat_ack,
    output in_ready, matriz, tamanho_matriz, mat_valid
  );

  modport master (
    output in_data, in_valid, mat_ack,
    input  in_ready, matriz, tamanho_matriz, mat_valid
  );
endinterface

// File: rtl/carregador_matriz.sv
// Packs signed 8-bit elements row-major into the 200-bit matrix bus for ula_determinante and holds it until acked.
// Optional abort input enabled by macro CARREGADOR_ABORT_EN.
module carregador_matriz #(
  parameter int LARGURA_ELEM = 8,
  parameter int MAX_ELEM     = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         tamanho_in,
`ifdef CARREGADOR_ABORT_EN
  input  logic               abort,
`endif
  output logic [4:0]         contagem,
  carregador_matriz_if.slave bus
);

  localparam int LARGURA_BUS = LARGURA_ELEM * MAX_ELEM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } estado_t;

  estado_t                        estado_reg;
  logic                           in_ready_reg;
  logic                           mat_valid_reg;
  logic signed [LARGURA_BUS-1:0]  matriz_reg;
  logic [1:0]                     tamanho_reg;
  logic [4:0]                     contagem_reg;
  logic [4:0]                     ultimo_idx;

  // Count value just before the final element: N*N - 1
  always_comb begin
    ultimo_idx = 5'd24;
    case (tamanho_reg)
      2'b00:   ultimo_idx = 5'd3;
      2'b01:   ultimo_idx = 5'd8;
      2'b10:   ultimo_idx = 5'd15;
      default: ultimo_idx = 5'd24;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_reg    <= IDLE;
      in_ready_reg  <= 1'b0;
      mat_valid_reg <= 1'b0;
      matriz_reg    <= '0;
      tamanho_reg   <= 2'b00;
      contagem_reg  <= 5'd0;
    end else begin
      case (estado_reg)
        IDLE: begin
          if (start) begin
            tamanho_reg  <= tamanho_in;
            matriz_reg   <= '0;
            contagem_reg <= 5'd0;
            in_ready_reg <= 1'b1;
            estado_reg   <= LOAD;
          end
        end

        LOAD: begin
`ifdef CARREGADOR_ABORT_EN
          if (abort) begin
            estado_reg    <= IDLE;
            in_ready_reg  <= 1'b0;
            mat_valid_reg <= 1'b0;
            matriz_reg    <= '0;
            contagem_reg  <= 5'd0;
          end else
`endif
          if (bus.in_valid && in_ready_reg) begin
            matriz_reg   <= {matriz_reg[LARGURA_BUS-LARGURA_ELEM-1:0], bus.in_data};
            contagem_reg <= contagem_reg + 5'd1;
            if (contagem_reg == ultimo_idx) begin
              in_ready_reg  <= 1'b0;
              mat_valid_reg <= 1'b1;
              estado_reg    <= HOLD;
            end
          end
        end

        HOLD: begin
`ifdef CARREGADOR_ABORT_EN
          if (abort) begin
            estado_reg    <= IDLE;
            in_ready_reg  <= 1'b0;
            mat_valid_reg <= 1'b0;
            matriz_reg    <= '0;
            contagem_reg  <= 5'd0;
          end else
`endif
          // matriz/tamanho stay as they are after the ack so the consumer may still read them
          if (bus.mat_ack) begin
            mat_valid_reg <= 1'b0;
            estado_reg    <= IDLE;
          end
        end

        default: begin
          estado_reg    <= IDLE;
          in_ready_reg  <= 1'b0;
          mat_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready       = in_ready_reg;
  assign bus.mat_valid      = mat_valid_reg;
  assign bus.matriz         = matriz_reg;
  assign bus.tamanho_matriz = tamanho_reg;
  assign contagem           = contagem_reg;

endmodule

// File: doc/carregador_matriz.md
# carregador_matriz

Input stage for `ula_determinante`. It receives signed 8-bit matrix elements one at a time over a valid/ready handshake and packs them row-major into the 200-bit `matriz` bus. It then presents the bus, with the matching `tamanho_matriz` code, to the determinant unit and holds both stable until the consumer acknowledges. It supports 2x2, 3x3, 4x4 and 5x5 matrices.

## Interface
Parameters:
- `LARGURA_ELEM`, 8: element width in bits. Fixed at 8 to match the `ula_determinante` bus.
- `MAX_ELEM`, 25: maximum element count (5x5). The bus width is `LARGURA_ELEM*MAX_ELEM` = 200.

Ports:
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begins a load. Sampled only in IDLE.
- `tamanho_in`  in  2: size code, latched on `start`. 00=2x2, 01=3x3, 10=4x4, 11=5x5.
- `in_data`  in  8 signed: matrix element.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: the block accepts an element this cycle.
- `matriz`  out  200 signed: packed matrix, connected to `ula_determinante.matriz`.
- `tamanho_matriz`  out  2: latched size code, connected to `ula_determinante.tamanho_matriz`.
- `mat_valid`  out  1: `matriz` and `tamanho_matriz` are complete and stable.
- `mat_ack`  in  1: consumer has taken the matrix.
- `contagem`  out  5: number of elements accepted so far in the current load.
- `abort`  in  1: present only when `CARREGADOR_ABORT_EN` is defined.

## Operation
- FSM states: IDLE, LOAD, HOLD.
- **IDLE:**
  - `in_ready`=0, `mat_valid`=0.
  - On `start`=1: latch `tamanho_in` into `tamanho_matriz`, clear `matriz` to 0, clear `contagem` to 0, go to LOAD.
- **LOAD:**
  - `in_ready`=1.
  - An element is accepted on an edge where `in_valid`&&`in_ready`.
  - On accept: `matriz <= {matriz[191:0], in_data}` and `contagem` increments.
  - Target count N² is 4, 9, 16 or 25 for codes 00/01/10/11.
  - On the accept that brings `contagem` to N²: go to HOLD.
- **HOLD:**
  - `in_ready`=0, `mat_valid`=1.
  - On `mat_ack`=1: go to IDLE and drop `mat_valid`.
  - `matriz` and `tamanho_matriz` keep their values after returning to IDLE, until the next `start`.
- **Packing result:** the first element received (row 0, column 0) ends in bits [8·N²−1 : 8·N²−8]. The last element received ends in [7:0]. Bits above 8·N² are 0.
- **Boundary conditions:**
  - `start` in LOAD or HOLD is ignored.
  - `tamanho_in` changes outside the `start` cycle have no effect.
  - `in_valid` in IDLE or HOLD is not accepted and `in_data` is discarded.
  - `start` and `in_valid` in the same IDLE cycle: only the start is taken; the first element can be accepted on the next cycle.
  - `mat_ack` outside HOLD is ignored.
  - `mat_ack` and `start` in the same HOLD cycle: the ack is taken, the start is ignored.
  - `contagem` never exceeds 25; no wrap-around is possible.
- **Reset** (async, any state): state=IDLE, `in_ready`=0, `mat_valid`=0, `matriz`=0, `tamanho_matriz`=00, `contagem`=0. A load in progress is discarded.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- `start` sampled at edge E0: `in_ready` is high after E0.
- With `in_valid` held at 1: the N-th accept occurs at edge E0+N².
- `mat_valid` rises after edge E0+N², together with `in_ready` falling.
- Minimum latency from `start` to `mat_valid` is N² cycles (4, 9, 16 or 25).
- Gaps in `in_valid` stretch the latency one cycle per gap.
- `mat_ack` sampled at edge E: `mat_valid` is 0 after E. A new `start` is accepted at E+1 at the earliest.
- The consumer samples `det`/`overflow_flag` while `mat_valid`=1. The bus is stable for the whole HOLD interval.

## Configuration
- Macro `CARREGADOR_ABORT_EN`.
- **Defined:**
  - Input `abort` exists.
  - `abort`=1 in LOAD or HOLD returns the block to IDLE on the next edge: `in_ready`=0, `mat_valid`=0, `contagem`=0, `matriz` cleared to 0.
  - `abort` has priority over an element accept and over `mat_ack` in the same cycle.
  - `abort` in IDLE is ignored.
- **Undefined:** no `abort` port and no abort logic. The only way out of LOAD is completing the load or reset.

## Test plan
- **2x2 load:** `tamanho_in`=00, elements 100, 50, 30, 60 back-to-back.
  - Required: `mat_valid` rises 4 cycles after `start`.
  - `matriz[31:0]`=32'h64321E3C, `matriz[199:32]`=0, `tamanho_matriz`=00.
- **3x3 load with gaps:** `tamanho_in`=01, elements 1..9, `in_valid` low every other cycle.
  - Required: `matriz[71:0]`=72'h010203040506070809.
  - `mat_valid` rises only after the 9th accept; `contagem`=9.
- **5x5 load:** elements 1..25.
  - Required: `matriz[199:192]`=8'd1, `matriz[7:0]`=8'd25.
  - `mat_valid` rises after exactly 25 accepts.
- **HOLD behaviour:**
  - With `mat_ack`=0 for 10 cycles, toggle `in_valid` and `start`. Required: `matriz` unchanged, `in_ready`=0.
  - Then pulse `mat_ack`. Required: `mat_valid`=0 next cycle, state IDLE.
- **Reset mid-load:** drop `rst_n` after 5 of 9 elements. Required: all outputs zero immediately.
  - A fresh 2x2 load afterwards completes correctly.
- **Abort (with `CARREGADOR_ABORT_EN`):** assert `abort` together with the 3rd element of a 3x3 load.
  - Required: element not accepted, `contagem`=0, `matriz`=0, IDLE next cycle.
